// File: rtl/ac_table_writer_pkg.sv
// Shared types and constants for the Aho-Corasick goto/failure tables.
// Used by both the table writer and the table reader.
package ac_pkg;

  localparam int STATE_W = 8;
  localparam int CHARA_W = 4;
  localparam int DEPTH   = 32;
  localparam int ADDR_W  = 5;

  localparam logic KIND_GOTO = 1'b0;
  localparam logic KIND_FAIL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [STATE_W-1:0] cur;
    logic [CHARA_W-1:0] chara;
    logic [STATE_W-1:0] next;
  } goto_entry_t;

  localparam int GOTO_W = $bits(goto_entry_t);

  // State 0 is the root and has no failure entry, so state s lives at s-1.
  function automatic logic [ADDR_W-1:0] fail_addr(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t;
    t = s - STATE_W'(1);
    return t[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ac_table_writer_if.sv
// Record stream from the pattern compiler/host into the table writer.
// A record transfers on a rising clock edge where WR_VALID and WR_READY are both 1;
// the master holds every WR_* field stable while WR_VALID is high and not yet accepted.
interface ac_table_writer_if;
  import ac_pkg::*;

  logic               WR_VALID;
  logic               WR_READY;
  logic               WR_KIND;
  logic [STATE_W-1:0] WR_CUR_STATE;
  logic [CHARA_W-1:0] WR_CHARA;
  logic [STATE_W-1:0] WR_NEXT_STATE;
  logic               WR_LAST;

  modport master (
    output WR_VALID, WR_KIND, WR_CUR_STATE, WR_CHARA, WR_NEXT_STATE, WR_LAST,
    input  WR_READY
  );

  modport slave (
    input  WR_VALID, WR_KIND, WR_CUR_STATE, WR_CHARA, WR_NEXT_STATE, WR_LAST,
    output WR_READY
  );

endinterface

// File: rtl/ac_table_ram.sv
// One-write / one-registered-read register array. The array itself has no reset;
// only the read register does. A same-address read and write returns the old data.
module ac_table_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ac_table_writer.sv
// Loads Aho-Corasick goto (append order) and failure (state-1) tables from a record stream.
// Optional AC_DUP_CHECK_EN drops goto records whose (cur, chara) is already stored and flags ERR_DUP.
module ac_table_writer
  import ac_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  ac_table_writer_if.slave   wr,
  input  logic [ADDR_W-1:0]  RD_ADDR,
  output logic [STATE_W-1:0] RD_CUR_STATE,
  output logic [CHARA_W-1:0] RD_CHARA,
  output logic [STATE_W-1:0] RD_NEXT_STATE,
  input  logic [ADDR_W-1:0]  RD_FAIL_ADDR,
  output logic [STATE_W-1:0] RD_FAIL_STATE,
  output logic [ADDR_W:0]    GOTO_COUNT,
  output logic               TABLE_VALID,
  output logic               ERR_OVERFLOW,
  output logic               ERR_BADSTATE,
`ifdef AC_DUP_CHECK_EN
  output logic               ERR_DUP,
`endif
  output state_e             DBG_STATE
);

  localparam logic [ADDR_W:0]    DEPTH_CNT   = (ADDR_W+1)'(DEPTH);
  localparam logic [STATE_W-1:0] DEPTH_STATE = STATE_W'(DEPTH);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              bad_q, bad_d;

  logic              accept;
  logic              is_goto;
  logic              goto_full;
  logic              bad_state;
  logic              goto_we;
  logic              fail_we;
  logic              dup_hit;
  goto_entry_t       goto_wdata;
  goto_entry_t       goto_rdata;

`ifdef AC_DUP_CHECK_EN
  logic [STATE_W+CHARA_W-1:0] key_q [DEPTH];
  logic                       dup_q, dup_d;

  // Parallel search over the populated prefix of the goto table.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((ADDR_W+1)'(i) < count_q) && (key_q[i] == {wr.WR_CUR_STATE, wr.WR_CHARA})) begin
        dup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    dup_d = dup_q;
    if (accept && is_goto && !goto_full && dup_hit) begin
      dup_d = 1'b1;
    end
    if (CLR) begin
      dup_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (goto_we) begin
      key_q[count_q[ADDR_W-1:0]] <= {wr.WR_CUR_STATE, wr.WR_CHARA};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dup_q <= 1'b0;
    end else begin
      dup_q <= dup_d;
    end
  end

  assign ERR_DUP = dup_q;
`else
  assign dup_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    bad_d     = bad_q;
    accept    = wr.WR_VALID && ready_q;
    is_goto   = (wr.WR_KIND == KIND_GOTO);
    goto_full = (count_q == DEPTH_CNT);
    bad_state = (wr.WR_CUR_STATE == '0) || (wr.WR_CUR_STATE > DEPTH_STATE);
    goto_we   = accept && is_goto && !goto_full && !dup_hit && !CLR;
    fail_we   = accept && !is_goto && !bad_state && !CLR;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = wr.WR_LAST ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept && wr.WR_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (goto_we) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end
    if (accept && is_goto && goto_full) begin
      ovf_d = 1'b1;
    end
    if (accept && !is_goto && bad_state) begin
      bad_d = 1'b1;
    end

    // Clear wins over any record arriving in the same cycle.
    if (CLR) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
      bad_d   = 1'b0;
    end

    // Ready is registered so it stays low through reset and the first edge after it.
    ready_d = (state_d != DONE);

    goto_wdata.cur   = wr.WR_CUR_STATE;
    goto_wdata.chara = wr.WR_CHARA;
    goto_wdata.next  = wr.WR_NEXT_STATE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
    end
  end

  ac_table_ram #(
    .WIDTH  (GOTO_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_goto_ram (
    .clk    (CLK),
    .rst    (RST),
    .we     (goto_we),
    .waddr  (count_q[ADDR_W-1:0]),
    .wdata  (goto_wdata),
    .raddr  (RD_ADDR),
    .rdata  (goto_rdata)
  );

  ac_table_ram #(
    .WIDTH  (STATE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fail_ram (
    .clk    (CLK),
    .rst    (RST),
    .we     (fail_we),
    .waddr  (fail_addr(wr.WR_CUR_STATE)),
    .wdata  (wr.WR_NEXT_STATE),
    .raddr  (RD_FAIL_ADDR),
    .rdata  (RD_FAIL_STATE)
  );

  assign wr.WR_READY    = ready_q;
  assign RD_CUR_STATE   = goto_rdata.cur;
  assign RD_CHARA       = goto_rdata.chara;
  assign RD_NEXT_STATE  = goto_rdata.next;
  assign GOTO_COUNT     = count_q;
  assign TABLE_VALID    = (state_q == DONE);
  assign ERR_OVERFLOW   = ovf_q;
  assign ERR_BADSTATE   = bad_q;
  assign DBG_STATE      = state_q;

endmodule

// File: tb/tb_ac_table_writer.sv
// Directed bench for ac_table_writer: load, failure table, overflow, clear, async reset.
// The duplicate-check scenario runs only when AC_DUP_CHECK_EN is defined.
module tb_ac_table_writer;
  import ac_pkg::*;

  // clock / reset
  logic CLK = 1'b0;
  logic RST;
  logic CLR;
  always #5 CLK = ~CLK;

  ac_table_writer_if wr();

  logic [ADDR_W-1:0]  RD_ADDR;
  logic [STATE_W-1:0] RD_CUR_STATE;
  logic [CHARA_W-1:0] RD_CHARA;
  logic [STATE_W-1:0] RD_NEXT_STATE;
  logic [ADDR_W-1:0]  RD_FAIL_ADDR;
  logic [STATE_W-1:0] RD_FAIL_STATE;
  logic [ADDR_W:0]    GOTO_COUNT;
  logic               TABLE_VALID;
  logic               ERR_OVERFLOW;
  logic               ERR_BADSTATE;
`ifdef AC_DUP_CHECK_EN
  logic               ERR_DUP;
`endif
  state_e             DBG_STATE;

  ac_table_writer dut (
    .CLK           (CLK),
    .RST           (RST),
    .CLR           (CLR),
    .wr            (wr.slave),
    .RD_ADDR       (RD_ADDR),
    .RD_CUR_STATE  (RD_CUR_STATE),
    .RD_CHARA      (RD_CHARA),
    .RD_NEXT_STATE (RD_NEXT_STATE),
    .RD_FAIL_ADDR  (RD_FAIL_ADDR),
    .RD_FAIL_STATE (RD_FAIL_STATE),
    .GOTO_COUNT    (GOTO_COUNT),
    .TABLE_VALID   (TABLE_VALID),
    .ERR_OVERFLOW  (ERR_OVERFLOW),
    .ERR_BADSTATE  (ERR_BADSTATE),
`ifdef AC_DUP_CHECK_EN
    .ERR_DUP       (ERR_DUP),
`endif
    .DBG_STATE     (DBG_STATE)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send(input logic kind, input logic [7:0] cur, input logic [3:0] ch,
                      input logic [7:0] nx, input logic last, input int gap);
    int n;
    n = 0;
    repeat ($urandom_range(0, gap)) @(negedge CLK);
    wr.WR_VALID      = 1'b1;
    wr.WR_KIND       = kind;
    wr.WR_CUR_STATE  = cur;
    wr.WR_CHARA      = ch;
    wr.WR_NEXT_STATE = nx;
    wr.WR_LAST       = last;
    while (!wr.WR_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!wr.WR_READY) begin
      check("send_ready_timeout", 32'(wr.WR_READY), 32'd1);
    end
    @(negedge CLK);
    wr.WR_VALID = 1'b0;
    wr.WR_LAST  = 1'b0;
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic read_goto(input string tag, input logic [4:0] a, input logic [7:0] c,
                           input logic [3:0] ch, input logic [7:0] nx);
    RD_ADDR = a;
    @(negedge CLK);
    check(tag, 32'({RD_CUR_STATE, RD_CHARA, RD_NEXT_STATE}), 32'({c, ch, nx}));
  endtask

  task automatic read_fail(input string tag, input logic [4:0] a, input logic [7:0] exp);
    RD_FAIL_ADDR = a;
    @(negedge CLK);
    check(tag, 32'(RD_FAIL_STATE), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    CLR = 1'b0;
    wr.WR_VALID = 1'b0; wr.WR_KIND = 1'b0; wr.WR_CUR_STATE = '0;
    wr.WR_CHARA = '0; wr.WR_NEXT_STATE = '0; wr.WR_LAST = 1'b0;
    RD_ADDR = '0;
    RD_FAIL_ADDR = '0;

    // reset state
    @(negedge CLK);
    check("rst_count", 32'(GOTO_COUNT), 32'd0);
    check("rst_valid", 32'(TABLE_VALID), 32'd0);
    check("rst_ready", 32'(wr.WR_READY), 32'd0);
    check("rst_ovf", 32'(ERR_OVERFLOW), 32'd0);
    check("rst_bad", 32'(ERR_BADSTATE), 32'd0);
    check("rst_rd_goto", 32'({RD_CUR_STATE, RD_CHARA, RD_NEXT_STATE}), 32'd0);
    check("rst_rd_fail", 32'(RD_FAIL_STATE), 32'd0);
    RST = 1'b0;
    #1;
    check("ready_before_edge", 32'(wr.WR_READY), 32'd0);
    @(negedge CLK);
    check("ready_after_edge", 32'(wr.WR_READY), 32'd1);
    check("state_idle", 32'(DBG_STATE), 32'(IDLE));

    // 1: three goto records
    send(KIND_GOTO, 8'd0, 4'h1, 8'd1, 1'b0, 0);
    check("t1_state_load", 32'(DBG_STATE), 32'(LOAD));
    send(KIND_GOTO, 8'd1, 4'h2, 8'd2, 1'b0, 0);
    send(KIND_GOTO, 8'd0, 4'hC, 8'd3, 1'b1, 0);
    check("t1_count", 32'(GOTO_COUNT), 32'd3);
    check("t1_valid", 32'(TABLE_VALID), 32'd1);
    check("t1_ready", 32'(wr.WR_READY), 32'd0);
    check("t1_state_done", 32'(DBG_STATE), 32'(DONE));
    read_goto("t1_rd2", 5'd2, 8'd0, 4'hC, 8'd3);
    read_goto("t1_rd0", 5'd0, 8'd0, 4'h1, 8'd1);
    read_goto("t1_rd1", 5'd1, 8'd1, 4'h2, 8'd2);

    // 2: failure records, including bad states 0 and 33
    clr_pulse();
    check("t2_clr_count", 32'(GOTO_COUNT), 32'd0);
    check("t2_clr_valid", 32'(TABLE_VALID), 32'd0);
    send(KIND_FAIL, 8'd1, 4'h0, 8'd4, 1'b0, 0);
    send(KIND_FAIL, 8'd2, 4'h0, 8'd0, 1'b0, 0);
    send(KIND_FAIL, 8'd3, 4'h0, 8'd1, 1'b0, 0);
    send(KIND_FAIL, 8'd32, 4'h0, 8'd7, 1'b0, 0);
    check("t2_bad_before", 32'(ERR_BADSTATE), 32'd0);
    send(KIND_FAIL, 8'd0, 4'h0, 8'd9, 1'b0, 0);
    check("t2_bad_state0", 32'(ERR_BADSTATE), 32'd1);
    send(KIND_FAIL, 8'd33, 4'h0, 8'd9, 1'b1, 0);
    check("t2_valid", 32'(TABLE_VALID), 32'd1);
    check("t2_goto_count", 32'(GOTO_COUNT), 32'd0);
    read_fail("t2_fail_a1", 5'd1, 8'd0);
    read_fail("t2_fail_a2", 5'd2, 8'd1);
    read_fail("t2_fail_a0", 5'd0, 8'd4);
    read_fail("t2_fail_a31", 5'd31, 8'd7);

    // 3: overflow
    clr_pulse();
    check("t3_clr_bad", 32'(ERR_BADSTATE), 32'd0);
    for (int i = 1; i <= 32; i++) begin
      send(KIND_GOTO, 8'(i), 4'(i), 8'(i + 1), 1'b0, 0);
    end
    check("t3_count32", 32'(GOTO_COUNT), 32'd32);
    check("t3_ovf_before", 32'(ERR_OVERFLOW), 32'd0);
    send(KIND_GOTO, 8'd33, 4'd1, 8'd34, 1'b1, 0);
    check("t3_count_held", 32'(GOTO_COUNT), 32'd32);
    check("t3_ovf", 32'(ERR_OVERFLOW), 32'd1);
    check("t3_valid", 32'(TABLE_VALID), 32'd1);
    read_goto("t3_rd31", 5'd31, 8'd32, 4'd0, 8'd33);
    read_goto("t3_rd0", 5'd0, 8'd1, 4'd1, 8'd2);

    // 4: random gaps, CLR with WR_VALID in DONE and in LOAD
    clr_pulse();
    check("t4_clr_ovf", 32'(ERR_OVERFLOW), 32'd0);
    send(KIND_GOTO, 8'd5, 4'd6, 8'd7, 1'b0, 3);
    send(KIND_GOTO, 8'd8, 4'd9, 8'd10, 1'b1, 3);
    check("t4_done_count", 32'(GOTO_COUNT), 32'd2);
    wr.WR_VALID = 1'b1; wr.WR_KIND = KIND_GOTO; wr.WR_CUR_STATE = 8'h99;
    wr.WR_CHARA = 4'h9; wr.WR_NEXT_STATE = 8'h99;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0; wr.WR_VALID = 1'b0;
    check("t4_clrdone_count", 32'(GOTO_COUNT), 32'd0);
    check("t4_clrdone_valid", 32'(TABLE_VALID), 32'd0);
    check("t4_clrdone_state", 32'(DBG_STATE), 32'(IDLE));
    send(KIND_GOTO, 8'h11, 4'h2, 8'h12, 1'b0, 2);
    send(KIND_GOTO, 8'h13, 4'h4, 8'h14, 1'b0, 2);
    check("t4_load_count", 32'(GOTO_COUNT), 32'd2);
    wr.WR_VALID = 1'b1; wr.WR_KIND = KIND_GOTO; wr.WR_CUR_STATE = 8'hAA;
    wr.WR_CHARA = 4'h5; wr.WR_NEXT_STATE = 8'hBB;
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0; wr.WR_VALID = 1'b0;
    check("t4_clrwr_count", 32'(GOTO_COUNT), 32'd0);
    check("t4_clrwr_state", 32'(DBG_STATE), 32'(IDLE));
    read_goto("t4_dropped_rd2", 5'd2, 8'd3, 4'd3, 8'd4);
    send(KIND_GOTO, 8'h21, 4'h7, 8'h22, 1'b0, 2);
    send(KIND_GOTO, 8'h23, 4'h8, 8'h24, 1'b1, 2);
    check("t4_reload_valid", 32'(TABLE_VALID), 32'd1);
    check("t4_reload_count", 32'(GOTO_COUNT), 32'd2);
    read_goto("t4_reload_rd1", 5'd1, 8'h23, 4'h8, 8'h24);
    read_goto("t4_reload_rd0", 5'd0, 8'h21, 4'h7, 8'h22);

    // 5: asynchronous reset mid-load
    clr_pulse();
    for (int i = 0; i < 5; i++) begin
      send(KIND_GOTO, 8'(i + 2), 4'(i), 8'(i + 3), 1'b0, 0);
    end
    check("t5_count5", 32'(GOTO_COUNT), 32'd5);
    #2;
    RST = 1'b1;
    #1;
    check("t5_async_count", 32'(GOTO_COUNT), 32'd0);
    check("t5_async_valid", 32'(TABLE_VALID), 32'd0);
    check("t5_async_state", 32'(DBG_STATE), 32'(IDLE));
    check("t5_async_ready", 32'(wr.WR_READY), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("t5_ready_after", 32'(wr.WR_READY), 32'd1);
    check("t5_valid_after", 32'(TABLE_VALID), 32'd0);

`ifdef AC_DUP_CHECK_EN
    // 6: duplicate goto record
    send(KIND_GOTO, 8'd1, 4'h2, 8'd2, 1'b0, 0);
    check("t6_dup_before", 32'(ERR_DUP), 32'd0);
    send(KIND_GOTO, 8'd1, 4'h2, 8'd2, 1'b1, 0);
    check("t6_count", 32'(GOTO_COUNT), 32'd1);
    check("t6_dup", 32'(ERR_DUP), 32'd1);
    check("t6_valid", 32'(TABLE_VALID), 32'd1);
    clr_pulse();
    check("t6_dup_clr", 32'(ERR_DUP), 32'd0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
